// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a fixed-latency FIFO read port into a first-word-fall-through valid/ready stream.
// Optional feature macro FIFO_READER_CNT_EN adds a 32-bit stream handshake counter on word_cnt.

module fifo_stream_reader #(
  parameter  int DATA_WIDTH = 32,
  parameter  int RD_LATENCY = 1,
  localparam int BUF_DEPTH  = RD_LATENCY + 2,
  localparam int LVL_W      = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush,
  output logic                  flush_busy,
  output logic [LVL_W-1:0]      buf_level
`ifdef FIFO_READER_CNT_EN
  ,
  output logic [31:0]           word_cnt
`endif
);

  localparam int PTR_W = $clog2(BUF_DEPTH);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t                state_q, state_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [LVL_W-1:0]      level_q;
  logic [LVL_W-1:0]      inflight, inflight_d;
  logic [LVL_W:0]        credit_used;
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic                  capture, pop, flush_start;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign m_valid     = (level_q != '0);
  assign m_data      = mem_q[head_q];
  assign buf_level   = level_q;
  assign pop         = m_valid & m_ready;
  assign capture     = vld_q[RD_LATENCY-1] & (state_q == S_RUN);
  assign flush_start = (state_q == S_RUN) & flush;

  // Credit check: a read is issued only if its word is guaranteed a buffer slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + LVL_W'(vld_q[i]);
    credit_used = {1'b0, level_q} + {1'b0, inflight};
    // NOTE: reset gates the read strobe so the FIFO is never popped while this block is held in reset.
    fifo_rd_en  = rd_rst_n & (state_q == S_RUN) & ~fifo_empty
                & (credit_used < (LVL_W + 1)'(BUF_DEPTH));
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    vld_d      = '0;
    vld_d[0]   = fifo_rd_en;
    for (int i = 1; i < RD_LATENCY; i++) vld_d[i] = vld_q[i-1];
    inflight_d = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight_d = inflight_d + LVL_W'(vld_d[i]);
  end

  always_comb begin
    state_d    = state_q;
    flush_busy = 1'b0;
    case (state_q)
      S_RUN:   if (flush) state_d = S_FLUSH;
      S_FLUSH: begin
        flush_busy = 1'b1;
        if (inflight_d == '0 && !flush) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q <= S_RUN;
      vld_q   <= '0;
      level_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      // NOTE: the small buffer is reset so m_data reads zero, never a stale word, after reset.
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      if (flush_start) begin
        level_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
      end else begin
        if (capture) begin
          mem_q[tail_q] <= fifo_rd_data;
          tail_q        <= wrap_inc(tail_q);
        end
        if (pop) head_q <= wrap_inc(head_q);
        level_q <= level_q + LVL_W'(capture) - LVL_W'(pop);
      end
    end
  end

`ifdef FIFO_READER_CNT_EN
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n)  word_cnt <= '0;
    else if (flush) word_cnt <= '0;
    else if (pop)   word_cnt <= word_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader: RD_LATENCY=1 and RD_LATENCY=2 instances share stream controls,
// each fed by its own FIFO model and checked against an in-order scoreboard of the FIFO contents.

module tb_fifo_stream_reader;

  localparam int DW = 32;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n = 1'b0;
  logic          m_ready = 1'b0;
  logic          flush = 1'b0;
  logic          fifo_empty [2];
  logic          fifo_rd_en [2];
  logic [DW-1:0] fifo_rd_data [2];
  logic          m_valid [2];
  logic [DW-1:0] m_data [2];
  logic          flush_busy [2];
  logic [1:0]    buf_level0;
  logic [2:0]    buf_level1;
`ifdef FIFO_READER_CNT_EN
  logic [31:0]   word_cnt [2];
`endif

  always #5 rd_clk = ~rd_clk;

  fifo_stream_reader #(.DATA_WIDTH(DW), .RD_LATENCY(1)) dut0 (
`ifdef FIFO_READER_CNT_EN
    .word_cnt(word_cnt[0]),
`endif
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .fifo_empty(fifo_empty[0]), .fifo_rd_en(fifo_rd_en[0]),
    .fifo_rd_data(fifo_rd_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready), .m_data(m_data[0]),
    .flush(flush), .flush_busy(flush_busy[0]), .buf_level(buf_level0)
  );

  fifo_stream_reader #(.DATA_WIDTH(DW), .RD_LATENCY(2)) dut1 (
`ifdef FIFO_READER_CNT_EN
    .word_cnt(word_cnt[1]),
`endif
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .fifo_empty(fifo_empty[1]), .fifo_rd_en(fifo_rd_en[1]),
    .fifo_rd_data(fifo_rd_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready), .m_data(m_data[1]),
    .flush(flush), .flush_busy(flush_busy[1]), .buf_level(buf_level1)
  );

  // Reference state: source words, per-FIFO read pointers, next expected stream word.
  logic [DW-1:0] src [1024];
  int            avail;
  int            rd_ptr [2];
  int            next_out [2];
  logic [DW-1:0] pipe [2][2];
  logic          prev_hold [2];
  logic [DW-1:0] prev_data [2];
  logic [31:0]   cnt_m [2];
  int            cyc, last_rd [2], first_rd [2], first_valid [2];
  int            hs_n [2], hs_first [2], hs_last [2], busy_n [2];
  int            errors, checks;

  function automatic int lat(input int d);
    return d + 1;
  endfunction

  function automatic int depth(input int d);
    return d + 3;
  endfunction

  function automatic int level_of(input int d);
    return (d == 0) ? int'(buf_level0) : int'(buf_level1);
  endfunction

  task automatic check(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d: observed=0x%0h expected=0x%0h", tag, d, obs, exp);
    end
  endtask

  task automatic refresh_empty();
    for (int d = 0; d < 2; d++) fifo_empty[d] = (rd_ptr[d] >= avail);
  endtask

  task automatic load(input int n, input logic [DW-1:0] base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      src[avail] = rnd ? DW'($urandom) : base + DW'(i);
      avail++;
    end
    refresh_empty();
  endtask

  task automatic clear_trk();
    for (int d = 0; d < 2; d++) begin
      hs_n[d] = 0; hs_first[d] = -1; hs_last[d] = -1;
      first_rd[d] = -1; first_valid[d] = -1; busy_n[d] = 0;
    end
  endtask

  task automatic check_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_rd_en"}, d, 64'(fifo_rd_en[d]), 64'd0);
      check({tag, "_valid"}, d, 64'(m_valid[d]), 64'd0);
      check({tag, "_data"}, d, 64'(m_data[d]), 64'd0);
      check({tag, "_busy"}, d, 64'(flush_busy[d]), 64'd0);
      check({tag, "_level"}, d, 64'(level_of(d)), 64'd0);
`ifdef FIFO_READER_CNT_EN
      check({tag, "_cnt"}, d, 64'(word_cnt[d]), 64'd0);
`endif
    end
  endtask

  // One clock: sample and check at the falling edge, then update the FIFO models just after the rising edge.
  task automatic step();
    logic rd_s [2];
    logic hs;
    @(negedge rd_clk);
    for (int d = 0; d < 2; d++) begin
      check("rd_en_while_empty", d, 64'(fifo_rd_en[d] & fifo_empty[d]), 64'd0);
      check("level_bound", d, 64'(level_of(d) <= depth(d)), 64'd1);
      check("valid_vs_level", d, 64'(m_valid[d]), 64'(level_of(d) != 0));
      if (prev_hold[d]) begin
        check("valid_held", d, 64'(m_valid[d]), 64'd1);
        check("data_held", d, 64'(m_data[d]), 64'(prev_data[d]));
      end
      hs = m_valid[d] & m_ready;
      if (hs) begin
        check("hs_after_read", d, 64'(next_out[d] < rd_ptr[d]), 64'd1);
        check("stream_data", d, 64'(m_data[d]), 64'(src[next_out[d]]));
        next_out[d]++;
        if (hs_first[d] < 0) hs_first[d] = cyc;
        hs_last[d] = cyc;
        hs_n[d]++;
      end
`ifdef FIFO_READER_CNT_EN
      check("word_cnt", d, 64'(word_cnt[d]), 64'(cnt_m[d]));
`endif
      if (flush) cnt_m[d] = '0;
      else if (hs) cnt_m[d] = cnt_m[d] + 32'd1;
      if (flush && !flush_busy[d]) next_out[d] = rd_ptr[d] + int'(fifo_rd_en[d]);
      if (m_valid[d] && first_valid[d] < 0) first_valid[d] = cyc;
      if (fifo_rd_en[d] && first_rd[d] < 0) first_rd[d] = cyc;
      if (fifo_rd_en[d]) last_rd[d] = cyc;
      if (flush_busy[d]) busy_n[d]++;
      prev_hold[d] = m_valid[d] & ~m_ready & ~flush;
      prev_data[d] = m_data[d];
      rd_s[d]      = fifo_rd_en[d];
    end
    @(posedge rd_clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      pipe[d][1] = pipe[d][0];
      if (rd_s[d]) begin
        pipe[d][0] = src[rd_ptr[d]];
        rd_ptr[d]++;
      end else begin
        pipe[d][0] = DW'($urandom);
      end
      fifo_rd_data[d] = pipe[d][d];
    end
    refresh_empty();
  endtask

  task automatic run_until_drained(input string tag, input int budget);
    int n = 0;
    while (!(next_out[0] == avail && next_out[1] == avail && !flush_busy[0] && !flush_busy[1])
           && n < budget) begin
      step();
      n++;
    end
    for (int d = 0; d < 2; d++) check({tag, "_drain_timeout"}, d, 64'(next_out[d] == avail), 64'd1);
  endtask

  task automatic wait_busy_done(input string tag, input int budget);
    int n = 0;
    while ((flush_busy[0] || flush_busy[1]) && n < budget) begin
      step();
      n++;
    end
    for (int d = 0; d < 2; d++) check({tag, "_busy_timeout"}, d, 64'(flush_busy[d]), 64'd0);
  endtask

  task automatic flush_and_check(input string tag, input int hold);
    int f, e;
    clear_trk();
    f = cyc;
    flush = 1'b1;
    repeat (hold) step();
    flush = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check({tag, "_valid_dropped"}, d, 64'(m_valid[d]), 64'd0);
      check({tag, "_busy_high"}, d, 64'(flush_busy[d]), 64'd1);
    end
    wait_busy_done(tag, 20);
    for (int d = 0; d < 2; d++) begin
      // Busy ends once every read issued up to the flush edge has returned and flush has dropped.
      e = f + hold;
      if (last_rd[d] + lat(d) - 1 > e) e = last_rd[d] + lat(d) - 1;
      if (last_rd[d] < f - lat(d)) e = f + hold;
      check({tag, "_busy_cycles"}, d, 64'(busy_n[d]), 64'(e - f));
    end
  endtask

  initial begin
    int n, c_load;
    errors = 0; checks = 0; avail = 0; cyc = 0;
    for (int i = 0; i < 1024; i++) src[i] = '0;
    for (int d = 0; d < 2; d++) begin
      rd_ptr[d] = 0; next_out[d] = 0; prev_hold[d] = 1'b0; cnt_m[d] = '0; last_rd[d] = -100;
      pipe[d][0] = '0; pipe[d][1] = '0; fifo_rd_data[d] = '0; fifo_empty[d] = 1'b1;
    end
    clear_trk();
    #12;
    check_reset("reset");
    rd_rst_n = 1'b1;
    repeat (2) step();

    // Three words, consumer always ready: latency and back-to-back delivery.
    m_ready = 1'b1;
    clear_trk();
    c_load = cyc;
    load(3, 32'h0, 1'b0);
    src[0] = 32'h11; src[1] = 32'h22; src[2] = 32'h33;
    run_until_drained("s1", 20);
    for (int d = 0; d < 2; d++) begin
      check("s1_first_read", d, 64'(first_rd[d]), 64'(c_load));
      check("s1_latency", d, 64'(first_valid[d] - first_rd[d]), 64'(lat(d) + 1));
      check("s1_count", d, 64'(hs_n[d]), 64'd3);
      check("s1_no_bubble", d, 64'(hs_last[d] - hs_first[d]), 64'd2);
    end

    // Eight words with consumer stalled: prefetch fills exactly the buffer, then drains at full rate.
    m_ready = 1'b0;
    n = rd_ptr[1];
    c_load = rd_ptr[0];
    load(8, 32'h100, 1'b0);
    repeat (10) step();
    check("s2_reads", 0, 64'(rd_ptr[0] - c_load), 64'(depth(0)));
    check("s2_reads", 1, 64'(rd_ptr[1] - n), 64'(depth(1)));
    for (int d = 0; d < 2; d++) begin
      check("s2_level", d, 64'(level_of(d)), 64'(depth(d)));
      check("s2_head", d, 64'(m_data[d]), 64'(src[next_out[d]]));
    end
    clear_trk();
    m_ready = 1'b1;
    run_until_drained("s2", 30);
    for (int d = 0; d < 2; d++) begin
      check("s2_count", d, 64'(hs_n[d]), 64'd8);
      check("s2_no_bubble", d, 64'(hs_last[d] - hs_first[d]), 64'd7);
    end

    // Six words with the consumer toggling ready every cycle.
    clear_trk();
    load(6, 32'hA0, 1'b0);
    n = 0;
    while (!(next_out[0] == avail && next_out[1] == avail) && n < 40) begin
      m_ready = ~m_ready;
      step();
      n++;
    end
    for (int d = 0; d < 2; d++) check("s3_count", d, 64'(hs_n[d]), 64'd6);

    // Flush with words buffered and in flight, then resume from the next unread FIFO word.
    m_ready = 1'b0;
    load(10, 32'h200, 1'b0);
    n = 0;
    while (buf_level1 != 3'd2 && n < 20) begin
      step();
      n++;
    end
    check("s4_fill_timeout", 1, 64'(buf_level1), 64'd2);
    flush_and_check("s4", 1);
    m_ready = 1'b1;
    run_until_drained("s4", 40);

    // Flush held for three cycles while streaming: extra requests are absorbed.
    load(6, 32'h300, 1'b0);
    repeat (3) step();
    flush_and_check("s4b", 3);
    run_until_drained("s4b", 40);

    // Asynchronous reset mid-stream: outputs clear at once and no returning word is captured.
    load(8, 32'h400, 1'b0);
    repeat (3) step();
    #1 rd_rst_n = 1'b0;
    #1 check_reset("midreset");
    #1 rd_rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      next_out[d] = rd_ptr[d]; prev_hold[d] = 1'b0; cnt_m[d] = '0;
    end
    run_until_drained("s5", 40);

`ifdef FIFO_READER_CNT_EN
    flush_and_check("s6a", 1);
    for (int d = 0; d < 2; d++) check("s6_cnt_clear", d, 64'(word_cnt[d]), 64'd0);
    load(5, 32'h500, 1'b0);
    run_until_drained("s6", 30);
    for (int d = 0; d < 2; d++) check("s6_cnt_5", d, 64'(word_cnt[d]), 64'd5);
    m_ready = 1'b0;
    flush_and_check("s6b", 1);
    for (int d = 0; d < 2; d++) check("s6_cnt_flushed", d, 64'(word_cnt[d]), 64'd0);
    m_ready = 1'b1;
    load(2, 32'h600, 1'b0);
    run_until_drained("s6c", 30);
    for (int d = 0; d < 2; d++) check("s6_cnt_2", d, 64'(word_cnt[d]), 64'd2);
`endif

    // Random traffic: random arrivals, back-pressure and occasional flushes.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0 && avail < 1000) load(int'($urandom_range(3, 1)), '0, 1'b1);
      m_ready = ($urandom_range(3) != 0);
      flush   = ($urandom_range(39) == 0);
      step();
    end
    flush   = 1'b0;
    m_ready = 1'b1;
    run_until_drained("rand", 80);
    for (int d = 0; d < 2; d++) begin
      check("end_level", d, 64'(level_of(d)), 64'd0);
      check("end_valid", d, 64'(m_valid[d]), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
